fir_interp2: RTL

Two-phase polyphase interpolate-by-2 FIR. It takes Q15 samples at the low rate through a valid/ready handshake and emits two Q2.15 output samples per input: the even phase, then the odd phase. It sits upstream of the DAC path as the rate-raising counterpart of the direct-form FIR. It shares that filter's Q15 coefficient format and 18-bit output format.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_interp2_if.sv | 17 +
 rtl/fir_interp2_mac.sv | 26 ++
 rtl/fir_interp2.sv | 113 +++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// fir_pkg -- widths, default prototype coefficients and FSM encoding for fir_interp2.
// Rev 1.0
package fir_pkg;

   localparam int DATA_W    = 16;
   localparam int OUT_W     = 18;
   localparam int FRAC      = 15;
   localparam int PROD_W    = 2 * DATA_W;
   localparam int NTAPS_DEF = 8;

   // Symmetric lowpass prototype; even taps feed phase 0, odd taps phase 1.
   localparam logic signed [DATA_W-1:0] COEF [NTAPS_DEF] = '{
      16'sh0100, 16'sh0800, 16'sh2000, 16'sh3800,
      16'sh3800, 16'sh2000, 16'sh0800, 16'sh0100
   };

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EVEN = 2'd1,
      S_ODD  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/fir_interp2_if.sv
`default_nettype none
// fir_interp2_if -- low-rate sample input and high-rate sample output of fir_interp2.
// Rev 1.0
interface fir_interp2_if;
   import fir_pkg::*;

   logic signed [DATA_W-1:0] i_x;
   logic                     i_valid;
   logic                     o_ready;
   logic [OUT_W-1:0]         o_y;
   logic                     o_valid;

   modport master (output i_x, i_valid, input o_ready, o_y, o_valid);
   modport slave  (input i_x, i_valid, output o_ready, o_y, o_valid);

endinterface
`default_nettype wire

// File: rtl/fir_interp2_mac.sv
`default_nettype none
// fir_interp2_mac -- combinational full-precision dot product of one polyphase branch.
// Rev 1.0
module fir_interp2_mac
   import fir_pkg::*;
#(
   parameter int NHALF = 4,
   parameter int ACC_W = PROD_W + $clog2(NHALF)
) (
   input  logic signed [DATA_W-1:0] d_i [NHALF],
   input  logic signed [DATA_W-1:0] h_i [NHALF],
   output logic signed [ACC_W-1:0]  acc_o
);

   logic signed [PROD_W-1:0] prod [NHALF];

   always_comb begin
      acc_o = '0;
      for (int k = 0; k < NHALF; k++) begin
         prod[k] = d_i[k] * h_i[k];
         acc_o   = acc_o + ACC_W'(prod[k]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/fir_interp2.sv
`default_nettype none
// fir_interp2 -- two-phase polyphase interpolate-by-2 FIR, Q15 in, Q2.15 out.
// Rev 1.0; optional output clamping with FIR_INTERP2_SAT_EN.
module fir_interp2
   import fir_pkg::*;
#(
   parameter int NTAPS = 8,
   parameter logic signed [DATA_W-1:0] COEF_SET [NTAPS] = COEF
) (
   input  logic         clk,
   input  logic         i_rst,
   fir_interp2_if.slave bus
);

   localparam int NHALF = NTAPS / 2;
   localparam int ACC_W = PROD_W + $clog2(NHALF);
   localparam int MSB   = OUT_W + FRAC - 1;

   state_t                   state_q, state_d;
   logic signed [DATA_W-1:0] dly_q [NHALF];
   logic signed [DATA_W-1:0] h_even [NHALF];
   logic signed [DATA_W-1:0] h_odd  [NHALF];
   logic signed [DATA_W-1:0] h_sel  [NHALF];
   logic signed [ACC_W-1:0]  acc;
   logic [OUT_W-1:0]         y_sat;
   logic [OUT_W-1:0]         y_q, y_d;
   logic                     valid_q, valid_d;
   logic                     ready;
   logic                     accept;
   logic                     acc_unused;

   for (genvar k = 0; k < NHALF; k++) begin : g_phase
      assign h_even[k] = COEF_SET[2*k];
      assign h_odd[k]  = COEF_SET[2*k+1];
   end

   always_comb begin
      for (int k = 0; k < NHALF; k++) begin
         h_sel[k] = (state_q == S_ODD) ? h_odd[k] : h_even[k];
      end
   end

   fir_interp2_mac #(
      .NHALF (NHALF),
      .ACC_W (ACC_W)
   ) u_mac (
      .d_i   (dly_q),
      .h_i   (h_sel),
      .acc_o (acc)
   );

   always_comb begin
      y_sat = acc[MSB:FRAC];
`ifdef FIR_INTERP2_SAT_EN
      // Bits above the Q2.15 window must all equal the sign for the slice to be exact.
      if (acc[ACC_W-1:MSB] != {(ACC_W-MSB){acc[ACC_W-1]}}) begin
         y_sat = acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
`endif
   end

   assign acc_unused = ^{acc[ACC_W-1:MSB+1], acc[FRAC-1:0]};

   assign ready  = (state_q != S_EVEN) && !i_rst;
   assign accept = bus.i_valid && ready;

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      valid_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_EVEN;
         end
         S_EVEN: begin
            y_d     = y_sat;
            valid_d = 1'b1;
            state_d = S_ODD;
         end
         S_ODD: begin
            y_d     = y_sat;
            valid_d = 1'b1;
            state_d = accept ? S_EVEN : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A back-to-back accept in S_ODD shifts at the same edge that registers y_o,
   // so the odd phase is always computed from the pre-shift delay line.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         y_q     <= '0;
         valid_q <= 1'b0;
         for (int k = 0; k < NHALF; k++) dly_q[k] <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         if (accept) begin
            dly_q[0] <= bus.i_x;
            for (int k = 1; k < NHALF; k++) dly_q[k] <= dly_q[k-1];
         end
      end
   end

   assign bus.o_ready = ready;
   assign bus.o_y     = y_q;
   assign bus.o_valid = valid_q;

endmodule
`default_nettype wire
